// File: rtl/boron_round_permutation_unit.sv
// boron_round_permutation_unit: iterative per-word rotate permutation with valid/ready handshakes.
// Optional BORON_RPERM_OPCNT_EN adds op_count_o, a count of completed output handshakes.
module boron_round_permutation_unit #(
    parameter int WORD_W = 16,
    parameter int NWORDS = 4,
    parameter logic [8*NWORDS-1:0] ROT_VEC = {8'd9, 8'd7, 8'd4, 8'd1},
    parameter int RND_W = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     mode_i,
    input  logic [RND_W-1:0]         rounds_i,
    input  logic [NWORDS*WORD_W-1:0] data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NWORDS*WORD_W-1:0] data_o,
    output logic                     busy_o
`ifdef BORON_RPERM_OPCNT_EN
    ,output logic [31:0]             op_count_o
`endif
);
    localparam int BW = NWORDS * WORD_W;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [BW-1:0] work, rotated;
    logic mode;
    logic [RND_W-1:0] cnt;
    logic accept;
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        localparam int AMT = int'(ROT_VEC[8*k +: 8]) % WORD_W;
        logic [2*WORD_W-1:0] dbl;
        // Slicing a doubled word gives a rotate without any shift-by-width corner case
        assign dbl = {work[k*WORD_W +: WORD_W], work[k*WORD_W +: WORD_W]};
        assign rotated[k*WORD_W +: WORD_W] = mode ? dbl[AMT +: WORD_W] : dbl[WORD_W-AMT +: WORD_W];
    end
    assign accept      = (state == IDLE) && in_valid_i;
    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state != IDLE);
    assign data_o      = work;
    always_comb begin
        state_nx = state;
        if (accept) state_nx = (rounds_i == '0) ? DONE : RUN;
        if (state == RUN && cnt == RND_W'(1)) state_nx = DONE;
        if (state == DONE && out_ready_i) state_nx = IDLE;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            work  <= '0;
            mode  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work <= data_i;
                mode <= mode_i;
                cnt  <= rounds_i;
            end else if (state == RUN) begin
                work <= rotated;
                cnt  <= cnt - RND_W'(1);
            end
        end
    end
`ifdef BORON_RPERM_OPCNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) op_count_o <= '0;
        else if (out_valid_o && out_ready_i) op_count_o <= op_count_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_boron_round_permutation_unit.sv
// tb_boron_round_permutation_unit: directed checks of the Boron round-permutation unit.
module tb_boron_round_permutation_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode = 1'b0;
    logic [4:0]  rounds = '0;
    logic [63:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] data_out;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
`ifdef BORON_RPERM_OPCNT_EN
    logic [31:0] op_count;
`endif

    boron_round_permutation_unit dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mode_i(mode), .rounds_i(rounds), .data_i(data_in), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .data_o(data_out), .busy_o(busy)
`ifdef BORON_RPERM_OPCNT_EN
        , .op_count_o(op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with the unit idle; junk is driven after accept.
    task automatic run_block(input string tag, input logic m, input logic [4:0] r,
                             input logic [63:0] d, input logic [63:0] exp, input bit deliver);
        int lat;
        in_valid = 1'b1; mode = m; rounds = r; data_in = d;
        @(posedge clk); #1;
        in_valid = 1'b0; mode = ~m; rounds = 5'd7; data_in = ~d;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(r));
        chk({tag, " data"}, data_out, exp);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
        if (deliver) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
            chk({tag, " ready back"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        #3;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset data", data_out, 64'd0);
`ifdef BORON_RPERM_OPCNT_EN
        chk("reset op_count", 64'(op_count), 64'd0);
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_block("dec r1", 1'b1, 5'd1, 64'h0001_0001_0001_0001, 64'h0080_0200_1000_8000, 1'b1);
`ifdef BORON_RPERM_OPCNT_EN
        chk("op_count after one", 64'(op_count), 64'd1);
`endif
        run_block("enc r1", 1'b0, 5'd1, 64'h0001_0001_0001_0001, 64'h0200_0080_0010_0002, 1'b1);
        run_block("enc r5", 1'b0, 5'd5, 64'h0123_4567_89AB_CDEF, 64'h6024_2B3A_9AB8_BDF9, 1'b1);
        run_block("dec r5", 1'b1, 5'd5, 64'h6024_2B3A_9AB8_BDF9, 64'h0123_4567_89AB_CDEF, 1'b1);
        run_block("dec r16", 1'b1, 5'd16, 64'hA5A5_3C3C_0F0F_1234, 64'hA5A5_3C3C_0F0F_1234, 1'b1);
        run_block("r0", 1'b0, 5'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);

        // Backpressure: result held while a competing input waits
        run_block("dec r2", 1'b1, 5'd2, 64'h0001_0001_0001_0001, 64'h4000_0004_0100_4000, 1'b0);
        in_valid = 1'b1; mode = 1'b0; rounds = 5'd1; data_in = 64'h0001_0001_0001_0001;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp data", data_out, 64'h4000_0004_0100_4000);
            chk("bp valid", 64'(out_valid), 64'd1);
            chk("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp handoff idle", 64'(busy), 64'd0);
        chk("bp handoff valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; data_in = '0;
        chk("bp accepted busy", 64'(busy), 64'd1);
        chk("bp accepted ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp next valid", 64'(out_valid), 64'd1);
        chk("bp next data", data_out, 64'h0200_0080_0010_0002);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a long run
        in_valid = 1'b1; mode = 1'b1; rounds = 5'd20; data_in = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid reset in_ready", 64'(in_ready), 64'd1);
        chk("mid reset valid", 64'(out_valid), 64'd0);
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset data", data_out, 64'd0);
`ifdef BORON_RPERM_OPCNT_EN
        chk("mid reset op_count", 64'(op_count), 64'd0);
`endif
        @(negedge clk); @(negedge clk); rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 25; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("no pulse after reset", 64'(seen), 64'd0);
        end
        run_block("post reset enc r1", 1'b0, 5'd1, 64'h0001_0001_0001_0001, 64'h0200_0080_0010_0002, 1'b1);
`ifdef BORON_RPERM_OPCNT_EN
        chk("op_count post reset", 64'(op_count), 64'd1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
